mt_thread_sched: RTL and testbench
==================================

# mt_thread_sched

Parametrised barrel-thread issue scheduler for the multithreaded RV32 core: it owns one program counter per hardware thread and, every cycle, offers one (thread id, PC) pair to the fetch stage over a valid/ready handshake. It generalises the fixed four-slot rotation of the current core. It adds:
- an arbitrary thread count;
- per-thread start/stop and stall masks;
- pipeline PC redirects;
- a selectable mode that either keeps strict slot timing or skips ineligible threads.

## Interface
- NUM_THREADS, 4: hardware threads, ≥1 (need not be a power of two).
- ADDRESS_WIDTH, 32: PC width.
- TID_WIDTH, $clog2(NUM_THREADS) (min 1): thread id width.
- RESET_PC, 0: base reset PC.
- PC_STRIDE, 0: reset PC of thread i = RESET_PC + i*PC_STRIDE.
- START_MASK, all ones: per-thread active bits after reset.
- SKIP_IDLE, 0: 0 = strict barrel (bubble in ineligible slot), 1 = skip to next eligible thread.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- issue_valid  out  1  an issue slot is offered.
- issue_ready  in  1  fetch accepts the offered slot.
- issue_tid  out  TID_WIDTH  thread of offered slot.
- issue_pc  out  ADDRESS_WIDTH  PC of offered slot.
- redir_en  in  1  PC redirect (branch/jump/trap) from pipeline.
- redir_tid  in  TID_WIDTH  redirected thread.
- redir_pc  in  ADDRESS_WIDTH  new PC.
- thread_start  in  NUM_THREADS  set active bit, one-hot or multi-hot.
- thread_stop  in  NUM_THREADS  clear active bit.
- stall_mask  in  NUM_THREADS  thread temporarily ineligible (e.g. waiting on dmem).
- active_mask  out  NUM_THREADS  current active bits.

## Operation
- State:
  - pc_table[NUM_THREADS];
  - active register;
  - rr_ptr, the last slot considered;
  - registered issue outputs.
- Reset (rst=0, asynchronous): pc_table[i]=RESET_PC+i*PC_STRIDE, active=START_MASK, rr_ptr=NUM_THREADS-1, issue_valid=0, issue_tid=0, issue_pc=0.
- Eligibility: elig = active & ~stall_mask, using the current-cycle inputs. Start/stop take effect on the next edge.
- Advance cycle: issue_valid==0 or issue_ready==1. On a non-advance cycle the outputs hold, except for the redirect and stop rules below.
- SKIP_IDLE=0: on advance, slot s = (rr_ptr+1) mod NUM_THREADS, and rr_ptr<=s. If elig[s], then issue_valid<=1, issue_tid<=s, issue_pc<=next PC of s; otherwise issue_valid<=0 (bubble).
- SKIP_IDLE=1: on advance, search round-robin from rr_ptr+1 for the first eligible thread. If one is found, issue it and set rr_ptr to its id. If none is eligible, issue_valid<=0 and rr_ptr is unchanged.
- Handshake (issue_valid & issue_ready): pc_table[issue_tid] <= issue_pc+4, modulo 2^ADDRESS_WIDTH (wraps to 0).
- Redirect: pc_table[redir_tid] <= redir_pc. This takes priority over the handshake increment for the same thread in the same cycle.
- Next-PC bypass for a selected thread t, in priority order: redir_pc if redir_en and redir_tid==t; else issue_pc+4 if a handshake for t occurs this cycle; else pc_table[t].
- Held slot redirected: issue_valid & ~issue_ready & redir_en & redir_tid==issue_tid → issue_pc<=redir_pc the next cycle; valid and tid are unchanged.
- Held slot stopped: thread_stop[issue_tid] while the slot is held → issue_valid<=0 next cycle; pc_table is unchanged.
- Start and stop of the same thread in the same cycle: stop wins.
- A redirect to an inactive thread still updates its PC; this is the boot method.
- redir_tid ≥ NUM_THREADS: ignored.

## Timing
- First issue_valid=1 appears on the first rising edge after rst deasserts. Issue latency is 1 cycle from eligibility to output.
- Throughput: one issue per cycle while issue_ready=1.
- Redirect visibility:
  - a redirect at edge k is used by any selection made at edge k;
  - the thread's next issued PC equals redir_pc.
- Stall/start/stop affect only selections made at or after the edge on which they are sampled.
- active_mask is registered and reflects start/stop one cycle after the input.

## Test plan
- Reset, N=4, SKIP_IDLE=0, PC_STRIDE=0x100, issue_ready=1 → tids 0,1,2,3,0 with PCs 0x000, 0x100, 0x200, 0x300, 0x004.
- SKIP_IDLE=0, stall_mask=0b0010 → sequence 0, bubble, 2, 3, 0. SKIP_IDLE=1, same stall → sequence 0, 2, 3, 0 with no bubble.
- N=1, SKIP_IDLE=1, issue_ready=1 → PCs 0, 4, 8 back-to-back, which exercises the bypass. A redirect to 0x80 during the issue of PC 4 → next PC is 0x80, not 8.
- issue_ready=0 for 3 cycles with tid 2 held → outputs stable and rr_ptr frozen. A redirect of tid 2 to 0x40 during the hold → issue_pc becomes 0x40. Release → tid 2 at 0x40 is accepted, then tid 3.
- A PC at 0xFFFFFFFC that handshakes → the next PC for that thread is 0x00000000. thread_stop and thread_start on the same thread in the same cycle → the thread ends up inactive.
- Asserting rst mid-stream while issue_valid=1 → issue_valid=0 and PCs return to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/mt_thread_sched.sv
// Barrel-thread issue scheduler: owns one PC per hardware thread and offers a
// registered (tid, pc) slot to fetch each cycle over a valid/ready handshake.
module mt_thread_sched #(
  parameter int unsigned              NUM_THREADS   = 4,
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              TID_WIDTH     = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [ADDRESS_WIDTH-1:0] PC_STRIDE     = '0,
  parameter logic [NUM_THREADS-1:0]   START_MASK    = '1,
  parameter bit                       SKIP_IDLE     = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [TID_WIDTH-1:0]     issue_tid,
  output logic [ADDRESS_WIDTH-1:0] issue_pc,
  input  logic                     redir_en,
  input  logic [TID_WIDTH-1:0]     redir_tid,
  input  logic [ADDRESS_WIDTH-1:0] redir_pc,
  input  logic [NUM_THREADS-1:0]   thread_start,
  input  logic [NUM_THREADS-1:0]   thread_stop,
  input  logic [NUM_THREADS-1:0]   stall_mask,
  output logic [NUM_THREADS-1:0]   active_mask
);

  logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];
  logic [NUM_THREADS-1:0]   active_q, active_d;
  logic [TID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic                     issue_valid_q, issue_valid_d;
  logic [TID_WIDTH-1:0]     issue_tid_q, issue_tid_d;
  logic [ADDRESS_WIDTH-1:0] issue_pc_q, issue_pc_d;

  logic [NUM_THREADS-1:0]   elig_c;
  logic [NUM_THREADS-1:0]   redir_hit_c;
  logic [NUM_THREADS-1:0]   hs_hit_c;
  logic                     handshake_c;
  logic                     advance_c;
  logic [ADDRESS_WIDTH-1:0] pc_inc_c;
  logic [TID_WIDTH-1:0]     strict_slot_c;
  logic [TID_WIDTH-1:0]     sel_tid_c;
  logic                     sel_found_c;
  logic [ADDRESS_WIDTH-1:0] sel_pc_c;

  assign elig_c      = active_q & ~stall_mask;
  assign handshake_c = issue_valid_q & issue_ready;
  assign advance_c   = ~issue_valid_q | issue_ready;
  assign pc_inc_c    = issue_pc_q + ADDRESS_WIDTH'(4);

  // Per-thread redirect / handshake hits; out-of-range redirect ids match nothing.
  always_comb begin : hit_decode
    redir_hit_c = '0;
    hs_hit_c    = '0;
    for (int i = 0; i < int'(NUM_THREADS); i++) begin
      redir_hit_c[i] = redir_en && (redir_tid == TID_WIDTH'(i));
      hs_hit_c[i]    = handshake_c && (issue_tid_q == TID_WIDTH'(i));
    end
  end

  // Next PC table; doubles as the bypass value for a thread selected this cycle.
  always_comb begin : pc_next
    for (int i = 0; i < int'(NUM_THREADS); i++) begin
      pc_d[i] = pc_q[i];
      if (redir_hit_c[i]) begin
        pc_d[i] = redir_pc;
      end else if (hs_hit_c[i]) begin
        pc_d[i] = pc_inc_c;
      end
    end
  end

  assign strict_slot_c = (rr_ptr_q == TID_WIDTH'(NUM_THREADS - 1)) ? TID_WIDTH'(0)
                                                                   : rr_ptr_q + 1'b1;

  // Slot selection: fixed next slot, or first eligible thread after rr_ptr.
  always_comb begin : select
    int unsigned idx;
    idx         = 0;
    sel_tid_c   = strict_slot_c;
    sel_found_c = elig_c[strict_slot_c];
    if (SKIP_IDLE) begin
      sel_tid_c   = rr_ptr_q;
      sel_found_c = 1'b0;
      for (int unsigned j = 1; j <= NUM_THREADS; j++) begin
        idx = 32'(rr_ptr_q) + j;
        if (idx >= NUM_THREADS) begin
          idx = idx - NUM_THREADS;
        end
        if (!sel_found_c && elig_c[TID_WIDTH'(idx)]) begin
          sel_found_c = 1'b1;
          sel_tid_c   = TID_WIDTH'(idx);
        end
      end
    end
  end

  assign sel_pc_c = pc_d[sel_tid_c];

  always_comb begin : next_state
    active_d      = (active_q | thread_start) & ~thread_stop;
    rr_ptr_d      = rr_ptr_q;
    issue_valid_d = issue_valid_q;
    issue_tid_d   = issue_tid_q;
    issue_pc_d    = issue_pc_q;
    if (advance_c) begin
      if (!SKIP_IDLE || sel_found_c) begin
        rr_ptr_d = sel_tid_c;
      end
      issue_valid_d = sel_found_c;
      if (sel_found_c) begin
        issue_tid_d = sel_tid_c;
        issue_pc_d  = sel_pc_c;
      end
    end else if (thread_stop[issue_tid_q]) begin
      issue_valid_d = 1'b0;
    end else if (redir_hit_c[issue_tid_q]) begin
      issue_pc_d = redir_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin : state_reg
    if (!rst) begin
      for (int i = 0; i < int'(NUM_THREADS); i++) begin
        pc_q[i] <= RESET_PC + ADDRESS_WIDTH'(i) * PC_STRIDE;
      end
      active_q      <= START_MASK;
      rr_ptr_q      <= TID_WIDTH'(NUM_THREADS - 1);
      issue_valid_q <= 1'b0;
      issue_tid_q   <= '0;
      issue_pc_q    <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_THREADS); i++) begin
        pc_q[i] <= pc_d[i];
      end
      active_q      <= active_d;
      rr_ptr_q      <= rr_ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_tid_q   <= issue_tid_d;
      issue_pc_q    <= issue_pc_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_tid   = issue_tid_q;
  assign issue_pc    = issue_pc_q;
  assign active_mask = active_q;

endmodule

// File: tb/tb_mt_thread_sched.sv
// Bench for mt_thread_sched: strict and skip-idle instances share stimulus; a
// reference model queues the expected offer per cycle and a monitor compares.
module tb_mt_thread_sched;

  localparam int N = 4;

  typedef struct {
    bit          v;
    int          tid;
    logic [31:0] pc;
    logic [3:0]  act;
  } offer_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ready = 1'b1;
  logic        redir_en = 1'b0;
  logic [1:0]  redir_tid = '0;
  logic [31:0] redir_pc = '0;
  logic [3:0]  thread_start = '0;
  logic [3:0]  thread_stop = '0;
  logic [3:0]  stall_mask = '0;

  logic        iv0, iv1;
  logic [1:0]  itid0, itid1;
  logic [31:0] ipc0, ipc1;
  logic [3:0]  am0, am1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mt_thread_sched #(.NUM_THREADS(4), .ADDRESS_WIDTH(32), .PC_STRIDE(32'h100), .SKIP_IDLE(1'b0)) u_strict (
    .clk(clk), .rst(rst), .issue_valid(iv0), .issue_ready(ready), .issue_tid(itid0), .issue_pc(ipc0),
    .redir_en(redir_en), .redir_tid(redir_tid), .redir_pc(redir_pc), .thread_start(thread_start),
    .thread_stop(thread_stop), .stall_mask(stall_mask), .active_mask(am0));

  mt_thread_sched #(.NUM_THREADS(4), .ADDRESS_WIDTH(32), .PC_STRIDE(32'h100), .SKIP_IDLE(1'b1)) u_skip (
    .clk(clk), .rst(rst), .issue_valid(iv1), .issue_ready(ready), .issue_tid(itid1), .issue_pc(ipc1),
    .redir_en(redir_en), .redir_tid(redir_tid), .redir_pc(redir_pc), .thread_start(thread_start),
    .thread_stop(thread_stop), .stall_mask(stall_mask), .active_mask(am1));

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst%0d got=%h want=%h t=%0t", name, k, got, want, $time);
    end
  endtask

  function automatic logic [31:0] get_v(input int k);
    return (k == 0) ? 32'(iv0) : 32'(iv1);
  endfunction
  function automatic logic [31:0] get_tid(input int k);
    return (k == 0) ? 32'(itid0) : 32'(itid1);
  endfunction
  function automatic logic [31:0] get_pc(input int k);
    return (k == 0) ? ipc0 : ipc1;
  endfunction
  function automatic logic [31:0] get_am(input int k);
    return (k == 0) ? 32'(am0) : 32'(am1);
  endfunction

  // Reference model state, per instance (0 = strict barrel, 1 = skip idle).
  logic [31:0] m_pc [2][N];
  logic [3:0]  m_act [2];
  int          m_rr [2];
  bit          m_v [2];
  int          m_tid [2];
  logic [31:0] m_opc [2];
  bit          live = 1'b0;
  offer_t      q0[$];
  offer_t      q1[$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) m_pc[k][i] = 32'(i) * 32'h100;
      m_act[k] = 4'hF;
      m_rr[k]  = N - 1;
      m_v[k]   = 1'b0;
      m_tid[k] = 0;
      m_opc[k] = '0;
    end
    q0.delete();
    q1.delete();
    live = 1'b0;
  endtask

  // PC a freshly selected thread t would be issued with this cycle.
  function automatic logic [31:0] next_pc(input int k, input int t, input bit hs);
    if (redir_en && int'(redir_tid) == t) return redir_pc;
    if (hs && m_tid[k] == t) return m_opc[k] + 32'd4;
    return m_pc[k][t];
  endfunction

  task automatic model_step(input int k);
    bit          hs;
    bit          nv;
    int          ntid;
    int          s;
    logic [31:0] npc;
    offer_t      o;
    hs   = m_v[k] && ready;
    nv   = m_v[k];
    ntid = m_tid[k];
    npc  = m_opc[k];
    if (!m_v[k] || ready) begin
      nv = 1'b0;
      for (int j = 1; j <= N; j++) begin
        s = (m_rr[k] + j) % N;
        if (k == 0 && j > 1) break;
        if (!nv && m_act[k][2'(s)] && !stall_mask[2'(s)]) begin
          nv   = 1'b1;
          ntid = s;
          npc  = next_pc(k, s, hs);
        end
      end
      if (k == 0) m_rr[k] = (m_rr[k] + 1) % N;
      else if (nv) m_rr[k] = ntid;
    end else if (thread_stop[2'(m_tid[k])]) begin
      nv = 1'b0;
    end else if (redir_en && int'(redir_tid) == m_tid[k]) begin
      npc = redir_pc;
    end
    if (hs) m_pc[k][m_tid[k]] = m_opc[k] + 32'd4;
    if (redir_en) m_pc[k][int'(redir_tid)] = redir_pc;
    m_act[k] = (m_act[k] | thread_start) & ~thread_stop;
    m_v[k]   = nv;
    m_tid[k] = ntid;
    m_opc[k] = npc;
    o.v   = nv;
    o.tid = ntid;
    o.pc  = npc;
    o.act = m_act[k];
    if (k == 0) q0.push_back(o);
    else q1.push_back(o);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        model_reset();
      end else begin
        model_step(0);
        model_step(1);
        live = 1'b1;
      end
    end
  end

  task automatic check_inst(input int k);
    offer_t e;
    bit     have;
    have = 1'b0;
    if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
    if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
    if (!have) begin
      if (live) begin
        total++;
        bad++;
        $display("FAIL sb_empty inst%0d no expected offer queued t=%0t", k, $time);
      end
      return;
    end
    chk("sb_valid", k, get_v(k), 32'(e.v));
    if (e.v) begin
      chk("sb_tid", k, get_tid(k), 32'(e.tid));
      chk("sb_pc", k, get_pc(k), e.pc);
    end
    chk("sb_active", k, get_am(k), 32'(e.act));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check_inst(0);
        check_inst(1);
      end
    end
  end

  task automatic wait_tid(input int t, output bit found);
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (iv0 && int'(itid0) == t) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int          p1_tid[5] = '{0, 1, 2, 3, 0};
    logic [31:0] p1_pc[5]  = '{32'h000, 32'h100, 32'h200, 32'h300, 32'h004};
    int          p2_v0[4]  = '{0, 1, 1, 1};
    int          p2_t0[4]  = '{0, 2, 3, 0};
    int          p2_t1[4]  = '{2, 3, 0, 2};
    logic [31:0] byp_pc[4] = '{32'h0, 32'h4, 32'h80, 32'h84};
    bit          found;

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, get_v(k), 32'd0);
      chk("rst_tid", k, get_tid(k), 32'd0);
      chk("rst_pc", k, get_pc(k), 32'd0);
      chk("rst_active", k, get_am(k), 32'hF);
    end
    rst = 1'b1;

    // Plain rotation with strided reset PCs.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("rot_valid", k, get_v(k), 32'd1);
        chk("rot_tid", k, get_tid(k), 32'(p1_tid[i]));
        chk("rot_pc", k, get_pc(k), p1_pc[i]);
      end
    end

    // Thread 1 stalled: bubble in strict mode, skipped in skip mode.
    stall_mask = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_strict_valid", 0, get_v(0), 32'(p2_v0[i]));
      if (p2_v0[i] != 0) chk("stall_strict_tid", 0, get_tid(0), 32'(p2_t0[i]));
      chk("stall_skip_valid", 1, get_v(1), 32'd1);
      chk("stall_skip_tid", 1, get_tid(1), 32'(p2_t1[i]));
    end
    stall_mask = 4'b0000;

    // Hold thread 2 for three cycles with a redirect in the middle.
    @(negedge clk);
    chk("hold_pre_tid", 0, get_tid(0), 32'd1);
    chk("hold_pre_pc", 0, get_pc(0), 32'h104);
    @(negedge clk);
    chk("hold_tid", 0, get_tid(0), 32'd2);
    chk("hold_pc", 0, get_pc(0), 32'h208);
    ready = 1'b0;
    @(negedge clk);
    chk("hold1_tid", 0, get_tid(0), 32'd2);
    chk("hold1_pc", 0, get_pc(0), 32'h208);
    redir_en = 1'b1; redir_tid = 2'd2; redir_pc = 32'h40;
    @(negedge clk);
    redir_en = 1'b0;
    chk("hold2_valid", 0, get_v(0), 32'd1);
    chk("hold2_pc", 0, get_pc(0), 32'h40);
    @(negedge clk);
    chk("hold3_tid", 0, get_tid(0), 32'd2);
    chk("hold3_pc", 0, get_pc(0), 32'h40);
    ready = 1'b1;
    @(negedge clk);
    chk("release_tid", 0, get_tid(0), 32'd3);
    chk("release_pc", 0, get_pc(0), 32'h308);

    // PC wrap at the top of the address space.
    redir_en = 1'b1; redir_tid = 2'd1; redir_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redir_en = 1'b0;
    wait_tid(1, found);
    chk("wrap_seen_hi", 0, 32'(found), 32'd1);
    chk("wrap_pc_hi", 0, get_pc(0), 32'hFFFF_FFFC);
    wait_tid(1, found);
    chk("wrap_seen_lo", 0, 32'(found), 32'd1);
    chk("wrap_pc_lo", 0, get_pc(0), 32'h0);

    // Start and stop of the same thread in one cycle: stop wins.
    thread_start = 4'b0001; thread_stop = 4'b0001;
    @(negedge clk);
    thread_start = 4'b0000; thread_stop = 4'b0000;
    for (int k = 0; k < 2; k++) chk("startstop_active", k, get_am(k), 32'hE);
    thread_start = 4'b0001;
    @(negedge clk);
    thread_start = 4'b0000;
    for (int k = 0; k < 2; k++) chk("restart_active", k, get_am(k), 32'hF);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4 && !iv0; i++) @(negedge clk);
    chk("pre_arst_valid", 0, get_v(0), 32'd1);
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_valid", k, get_v(k), 32'd0);
      chk("arst_tid", k, get_tid(k), 32'd0);
      chk("arst_pc", k, get_pc(k), 32'd0);
      chk("arst_active", k, get_am(k), 32'hF);
    end
    stall_mask = 4'b1110;
    @(negedge clk);
    rst = 1'b1;

    // Single eligible thread back-to-back in skip mode: PC bypass and redirect.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      redir_en = 1'b0;
      chk("byp_valid", 1, get_v(1), 32'd1);
      chk("byp_tid", 1, get_tid(1), 32'd0);
      chk("byp_pc", 1, get_pc(1), byp_pc[i]);
      if (i == 1) begin
        redir_en = 1'b1; redir_tid = 2'd0; redir_pc = 32'h80;
      end
    end
    stall_mask = 4'b0000;

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ready        = ($urandom_range(0, 3) != 0);
      redir_en     = ($urandom_range(0, 5) == 0);
      redir_tid    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       redir_pc = 32'hFFFF_FFFC;
        1:       redir_pc = 32'hFFFF_FFF8;
        2:       redir_pc = $urandom & 32'hFFFF_FFFC;
        default: redir_pc = 32'($urandom_range(0, 255)) << 2;
      endcase
      stall_mask   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      thread_start = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      thread_stop  = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
    end

    @(negedge clk);
    ready = 1'b1; redir_en = 1'b0; stall_mask = '0; thread_start = '0; thread_stop = '0;
    repeat (6) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
